// File: rtl/forth_dmem_arbiter.sv
// forth_dmem_arbiter
//
// Shares the single-port synchronous data RAM behind the forth core's data
// port between the core and a host/debug requester. The core normally owns
// the RAM; an idle-core host request is granted at once, and a host request
// that has been denied HOST_WAIT consecutive cycles is forced through. When
// that happens the core is stalled for the cycle and must re-present its
// request.
//
// Grant is combinational per cycle. A registered owner state records who drove
// the RAM in the previous cycle, so read data coming back from the
// 1-cycle-latency RAM is routed to the right requester.
//
// Parameters
//   AW         data address width (matches core daddr)
//   DW         data word width
//   HOST_WAIT  max consecutive host denials before a forced grant (1..15)
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   cpu_req      core requests a data access this cycle
//   cpu_we       core write strobe
//   cpu_addr     core address
//   cpu_wdata    core write data
//   cpu_rdata    read data to core, valid the cycle after a core grant
//   cpu_stall    core must hold its state and re-present the request
//   host_req     host request, held stable until host_ack
//   host_we      host write strobe
//   host_addr    host address
//   host_wdata   host write data
//   host_ack     1-cycle pulse: host access accepted this cycle
//   host_rdata   host read data, valid when host_rvalid
//   host_rvalid  1-cycle pulse, the cycle after host_ack of a read
//   conflict_cnt (FORTH_DARB_CONFLICT_CNT_EN only) saturating count of
//                cycles with cpu_req and host_req both high
//   mem_addr     RAM address
//   mem_we       RAM write enable
//   mem_wdata    RAM write data
//   mem_rdata    RAM read data, 1-cycle latency after address
//
// Build option
//   FORTH_DARB_CONFLICT_CNT_EN  adds the conflict_cnt output and its counter.

module forth_dmem_arbiter #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 16,
    parameter int unsigned HOST_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,

`ifdef FORTH_DARB_CONFLICT_CNT_EN
    output logic [15:0]   conflict_cnt,
`endif

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StOwnCpu  = 2'd1,
        StOwnHost = 2'd2
    } owner_e;

    localparam logic [3:0] HostWaitC = 4'(HOST_WAIT);

    owner_e        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic          host_rd_q, host_rd_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic          host_grant;
    logic          cpu_grant;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            wait_q       <= 4'd0;
            host_rd_q    <= 1'b0;
            addr_q       <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            host_rd_q    <= host_rd_d;
            addr_q       <= mem_addr;
            cpu_rdata_q  <= cpu_rdata;
            host_rdata_q <= host_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration, RAM drive and next state
    // ------------------------------------------------------------------
    always_comb begin
        host_grant = 1'b0;
        cpu_grant  = 1'b0;
        state_d    = StIdle;
        wait_d     = wait_q;
        host_rd_d  = 1'b0;
        mem_addr   = addr_q;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        host_ack   = 1'b0;
        cpu_stall  = 1'b0;

        // Grants are masked while reset is low so no RAM write or handshake
        // can leak out before the registers are released.
        if (reset) begin
            host_grant = host_req && (!cpu_req || (wait_q == HostWaitC));
            cpu_grant  = cpu_req && !host_grant;

            if (host_grant) begin
                state_d   = StOwnHost;
                host_rd_d = !host_we;
                mem_addr  = host_addr;
                mem_we    = host_we;
                mem_wdata = host_wdata;
                host_ack  = 1'b1;
                cpu_stall = cpu_req;
            end else if (cpu_grant) begin
                state_d   = StOwnCpu;
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end

            // Starvation counter: counts consecutive denials, saturating at
            // HOST_WAIT, which is the level that forces the next grant.
            if (!host_req || host_grant) begin
                wait_d = 4'd0;
            end else if (wait_q < HostWaitC) begin
                wait_d = wait_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return routing: pass RAM data through in the cycle after the
    // owning grant, otherwise hold the last value delivered.
    // ------------------------------------------------------------------
    always_comb begin
        host_rvalid = (state_q == StOwnHost) && host_rd_q;
        cpu_rdata   = (state_q == StOwnCpu) ? mem_rdata : cpu_rdata_q;
        host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
    end

`ifdef FORTH_DARB_CONFLICT_CNT_EN
    // ------------------------------------------------------------------
    // Contention statistics
    // ------------------------------------------------------------------
    logic [15:0] conflict_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= 16'd0;
        end else if (cpu_req && host_req && (conflict_q != 16'hffff)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_forth_dmem_arbiter.sv
module tb_forth_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef FORTH_DARB_CONFLICT_CNT_EN
    logic [15:0]   conflict_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] host_exp_q[$];
    bit            cpu_pend = 1'b0;

    forth_dmem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .HOST_WAIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
`ifdef FORTH_DARB_CONFLICT_CNT_EN
        .conflict_cnt(conflict_cnt),
`endif
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, 1-cycle read latency, read-before-write.
    // Unwritten words read as 16'h1000 + address.
    logic [DW-1:0] ram [logic [AW-1:0]];
    always @(posedge clk) begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : (16'h1000 + 16'(mem_addr));
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: pops expected read data whenever a read return is due.
    always @(negedge clk) begin
        if (cpu_pend) begin
            if (cpu_exp_q.size() == 0) check("cpu_exp_q_size", cpu_exp_q.size(), 1);
            else check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
        end
        cpu_pend = reset && cpu_req && !cpu_we && !cpu_stall;
        if (host_rvalid) begin
            if (host_exp_q.size() == 0) check("host_rvalid_spurious", host_rvalid, 0);
            else check("host_rdata", host_rdata, host_exp_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after the access is granted.
    task automatic cpu_op(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                          input logic [15:0] want);
        int n = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (!we) cpu_exp_q.push_back(want);
        @(negedge clk);
        while (cpu_stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("cpu_grant_timeout", cpu_stall, 0);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic host_op(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                           input int exp_wait, input logic [15:0] want, input bit expect_rv,
                           input string name);
        int waited = 0;
        bit stall_early = 1'b0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        if (!we && expect_rv) host_exp_q.push_back(want);
        @(negedge clk);
        while (!host_ack && waited < 20) begin
            if (cpu_stall) stall_early = 1'b1;
            waited++;
            @(negedge clk);
        end
        check({name, "_ack_wait"}, waited, exp_wait);
        check({name, "_stall_denied"}, 32'(stall_early), 0);
        check({name, "_stall_at_ack"}, cpu_stall, cpu_req);
        @(posedge clk);
        #1;
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset released mid-cycle
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        check("rst_host_ack", host_ack, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        @(posedge clk);
        #1;

        // First core read
        cpu_op(1'b0, 8'h10, 16'h0, 16'h1010);

        // Host only: write, read back, back-to-back read in the rvalid cycle
        host_op(1'b1, 8'h20, 16'h1234, 0, 16'h0, 1'b0, "host_wr");
        host_op(1'b0, 8'h20, 16'h0, 0, 16'h1234, 1'b1, "host_rd");
        host_op(1'b0, 8'h05, 16'h0, 0, 16'h1005, 1'b1, "host_b2b");

        // Contention: core reads continuously, host forced in after 4 denials
        fork
            begin
                repeat (6) cpu_op(1'b0, 8'h11, 16'h0, 16'h1011);
            end
            host_op(1'b0, 8'h05, 16'h0, 4, 16'h1005, 1'b1, "contend");
        join

        // Same address, same cycle: core write wins, host sees it later
        fork
            cpu_op(1'b1, 8'h30, 16'hbeef, 16'h0);
            host_op(1'b0, 8'h30, 16'h0, 1, 16'hbeef, 1'b1, "same_addr");
        join

        // Reset in the cycle after a host read ack drops the rvalid
        host_op(1'b0, 8'h40, 16'h0, 0, 16'h0, 1'b0, "rst_rd");
        reset     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h55;
        host_req  = 1'b1;
        host_we   = 1'b1;
        host_addr = 8'h66;
        @(negedge clk);
        check("mid_rst_host_rvalid", host_rvalid, 0);
        check("mid_rst_host_ack", host_ack, 0);
        check("mid_rst_cpu_stall", cpu_stall, 0);
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_host_rdata", host_rdata, 0);
        check("mid_rst_cpu_rdata", cpu_rdata, 0);
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        host_req = 1'b0;
        host_we  = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        host_op(1'b0, 8'h40, 16'h0, 0, 16'h1040, 1'b1, "reissue");

`ifdef FORTH_DARB_CONFLICT_CNT_EN
        check("conflict_cnt_start", conflict_cnt, 0);
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 8'h70;
        cpu_wdata  = 16'h0070;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h71;
        host_wdata = 16'h0071;
        repeat (7) @(posedge clk);
        #1;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        host_req = 1'b0;
        host_we  = 1'b0;
        @(negedge clk);
        check("conflict_cnt_7", conflict_cnt, 7);
        reset = 1'b0;
        @(negedge clk);
        check("conflict_cnt_rst", conflict_cnt, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
`endif

        repeat (3) @(negedge clk);
        check("host_exp_q_drained", host_exp_q.size(), 0);
        check("cpu_exp_q_drained", cpu_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
